// File: rtl/sha256_digest_reader.sv
// Purpose: reads DIGEST_WORDS 32-bit words from shared memory, streams them out, and compares them with a reference digest.
// Latency: out_valid rises 2 edges after start; 3 cycles per word with out_ready high; done pulses 3*DIGEST_WORDS edges after start.
// Backpressure: out_ready low holds the offered word and stalls the whole read indefinitely; start is only sampled in IDLE.
//
// Ports:
//   clk, reset_n                   clock, async active-low reset
//   start, digest_addr, expected   run request, word address of digest word 0, reference digest (word 0 in MSBs)
//   mem_clk, mem_we, mem_addr      memory port (mem_clk = clk, never writes, registered word address)
//   mem_read_data                  memory data, valid the cycle after mem_addr is presented
//   out_valid/out_ready/out_data/out_last   digest word stream
//   done, match, mismatch_idx      run-complete pulse, overall compare result, first failing word index
module sha256_digest_reader #(
    parameter int DIGEST_WORDS = 8
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [15:0]               digest_addr,
    input  logic [32*DIGEST_WORDS-1:0] expected,
    output logic                      mem_clk,
    output logic                      mem_we,
    output logic [31:0]               mem_addr,
    input  logic [31:0]               mem_read_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [31:0]               out_data,
    output logic                      out_last,
    output logic                      done,
    output logic                      match,
    output logic [7:0]                mismatch_idx
);

    localparam logic [7:0] LAST_IDX = 8'(DIGEST_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        CAPTURE = 2'd2,
        EMIT    = 2'd3
    } state_t;

    state_t                     state;
    state_t                     state_nxt;
    logic [7:0]                 idx;
    logic [15:0]                addr_lat;
    logic [32*DIGEST_WORDS-1:0] exp_lat;
    logic                       all_ok;     // AND of every compare so far in this run
    logic [31:0]                cur_exp;
    logic                       accept;
    logic                       handshake;
    logic                       at_last;
    logic                       word_ok;

    assign mem_clk = clk;
    assign mem_we  = 1'b0;

    assign accept    = (state == IDLE) && start;
    assign handshake = (state == EMIT) && out_valid && out_ready;
    assign at_last   = (idx == LAST_IDX);
    assign word_ok   = (mem_read_data == cur_exp);

    // Word 0 lives in the MSBs of the latched reference.
    always_comb begin
        cur_exp = 32'h0;
        for (int i = 0; i < DIGEST_WORDS; i++) begin
            if (idx == 8'(i)) begin
                cur_exp = exp_lat[32*(DIGEST_WORDS-1-i) +: 32];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = WAIT;
            WAIT:    state_nxt = CAPTURE;
            CAPTURE: state_nxt = EMIT;
            EMIT:    if (handshake) state_nxt = at_last ? IDLE : WAIT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            idx          <= 8'h0;
            addr_lat     <= 16'h0;
            exp_lat      <= '0;
            all_ok       <= 1'b0;
            mem_addr     <= 32'h0;
            out_data     <= 32'h0;
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            done         <= 1'b0;
            match        <= 1'b0;
            mismatch_idx <= 8'h0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                addr_lat     <= digest_addr;
                exp_lat      <= expected;
                idx          <= 8'h0;
                all_ok       <= 1'b1;
                match        <= 1'b0;
                mismatch_idx <= 8'h0;
                mem_addr     <= {16'h0, digest_addr};
            end
            if (state == CAPTURE) begin
                out_data  <= mem_read_data;
                out_valid <= 1'b1;
                out_last  <= at_last;
                if (!word_ok) begin
                    all_ok <= 1'b0;
                    // Only the first failing word is recorded.
                    if (all_ok) begin
                        mismatch_idx <= idx;
                    end
                end
            end
            if (handshake) begin
                out_valid <= 1'b0;
                if (at_last) begin
                    out_last <= 1'b0;
                    match    <= all_ok;
                    done     <= 1'b1;
                end else begin
                    idx      <= idx + 8'd1;
                    // 16-bit sum wraps 16'hFFFF to 16'h0000 by construction.
                    mem_addr <= {16'h0, addr_lat + {8'h0, idx} + 16'd1};
                end
            end
        end
    end

endmodule

// File: tb/tb_sha256_digest_reader.sv
module tb_sha256_digest_reader;

    localparam int N = 8;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [15:0]       digest_addr;
    logic [32*N-1:0]   expected;
    logic              mem_clk;
    logic              mem_we;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_read_data;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_data;
    logic              out_last;
    logic              done;
    logic              match;
    logic [7:0]        mismatch_idx;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    logic [31:0] mem [0:65535];
    logic [31:0] abc [0:N-1];

    // Results gathered by run_collect
    logic [31:0] got_q[$];
    bit          last_q[$];
    logic [31:0] addr_q[$];
    int          stall_err;
    int          done_edge;
    int          hs_edge;
    logic        got_match;
    logic [7:0]  got_midx;

    sha256_digest_reader #(.DIGEST_WORDS(N)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .digest_addr   (digest_addr),
        .expected      (expected),
        .mem_clk       (mem_clk),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_read_data (mem_read_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_last      (out_last),
        .done          (done),
        .match         (match),
        .mismatch_idx  (mismatch_idx)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory: data for the address presented in one cycle appears in the next.
    always @(posedge clk) mem_read_data <= mem[mem_addr[15:0]];

    function automatic logic [31:0] mword(input logic [15:0] a, input int i);
        logic [15:0] ad;
        ad = a + 16'(i);
        return mem[ad];
    endfunction

    task automatic set_expected(input logic [31:0] w [0:N-1]);
        for (int i = 0; i < N; i++) expected[32*(N-1-i) +: 32] = w[i];
    endtask

    // Starts one run (called just after a rising edge) and records what the stream and memory port do.
    task automatic run_collect(input logic [15:0] a, input bit rnd_ready, input bit scramble);
        logic [31:0]     pd;
        logic            pl;
        logic            pv;
        int              e;
        logic [32*N-1:0] saved;
        got_q.delete(); last_q.delete(); addr_q.delete();
        stall_err = 0; done_edge = -1; hs_edge = -1; got_match = 1'bx; got_midx = 8'hxx;
        saved = expected;
        digest_addr = a;
        start = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (scramble) expected = ~expected;
        e = 0;
        pv = 1'b0; pd = 32'h0; pl = 1'b0;
        addr_q.push_back(mem_addr);
        while (e < 400) begin
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (pv && (out_data !== pd || out_last !== pl)) stall_err++;
            pv = out_valid; pd = out_data; pl = out_last;
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                last_q.push_back(out_last);
                hs_edge = e + 1;
                pv = 1'b0;
            end
            @(posedge clk); #1;
            e++;
            if (mem_addr !== addr_q[$]) addr_q.push_back(mem_addr);
            if (done) begin
                done_edge = e; got_match = match; got_midx = mismatch_idx;
                break;
            end
        end
        expected = saved;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; digest_addr = 16'h0; expected = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_cnt++; if ({out_valid, out_last, done, match} !== 4'b0) $display("FAIL reset_flags got %b want 0000", {out_valid, out_last, done, match}); else pass_cnt++;
        chk_cnt++; if (out_data !== 32'h0) $display("FAIL reset_out_data got %h want 0", out_data); else pass_cnt++;
        chk_cnt++; if (mem_addr !== 32'h0) $display("FAIL reset_mem_addr got %h want 0", mem_addr); else pass_cnt++;
        chk_cnt++; if (mismatch_idx !== 8'h0) $display("FAIL reset_midx got %0d want 0", mismatch_idx); else pass_cnt++;
        chk_cnt++; if (mem_we !== 1'b0 || mem_clk !== clk) $display("FAIL mem_we_clk got we=%b clk=%b want we=0 clk=%b", mem_we, mem_clk, clk); else pass_cnt++;
        @(posedge clk); #1;
        reset_n = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_cnt++; if (mem_addr !== 32'h0 || out_valid !== 1'b0) $display("FAIL post_reset_idle got addr=%h valid=%b want 0/0", mem_addr, out_valid); else pass_cnt++;
    endtask

    task automatic test_abc();
        int nlast;
        for (int i = 0; i < N; i++) mem[16'h0010 + 16'(i)] = abc[i];
        set_expected(abc);
        run_collect(16'h0010, 1'b0, 1'b1);
        chk_cnt++; if (done_edge !== 24) $display("FAIL abc_done_edge got %0d want 24", done_edge); else pass_cnt++;
        chk_cnt++; if (got_q.size() !== N) $display("FAIL abc_word_count got %0d want %0d", got_q.size(), N); else pass_cnt++;
        nlast = 0;
        for (int i = 0; i < got_q.size() && i < N; i++) begin
            chk_cnt++; if (got_q[i] !== abc[i]) $display("FAIL abc_word%0d got %h want %h", i, got_q[i], abc[i]); else pass_cnt++;
            if (last_q[i] && i == N - 1) nlast++;
            if (last_q[i] && i != N - 1) nlast += 100;
        end
        chk_cnt++; if (nlast !== 1) $display("FAIL abc_last got code %0d want 1", nlast); else pass_cnt++;
        chk_cnt++; if (got_match !== 1'b1 || got_midx !== 8'h0) $display("FAIL abc_match got %b/%0d want 1/0", got_match, got_midx); else pass_cnt++;
        chk_cnt++; if (addr_q.size() !== N) $display("FAIL abc_addr_count got %0d want %0d", addr_q.size(), N); else pass_cnt++;
        @(posedge clk); #1;
        chk_cnt++; if (done !== 1'b0 || match !== 1'b1) $display("FAIL abc_done_pulse got done=%b match=%b want 0/1", done, match); else pass_cnt++;
    endtask

    task automatic test_mismatch();
        logic [31:0] mw;
        mem[16'h0015] = 32'hDEADBEEF;
        mem[16'h0016] = abc[6] ^ 32'h0000_0100;
        set_expected(abc);
        run_collect(16'h0010, 1'b0, 1'b0);
        chk_cnt++; if (done_edge !== 24) $display("FAIL mm_done_edge got %0d want 24", done_edge); else pass_cnt++;
        chk_cnt++; if (got_match !== 1'b0 || got_midx !== 8'd5) $display("FAIL mm_result got %b/%0d want 0/5", got_match, got_midx); else pass_cnt++;
        for (int i = 0; i < got_q.size() && i < N; i++) begin
            mw = mword(16'h0010, i);
            chk_cnt++; if (got_q[i] !== mw) $display("FAIL mm_word%0d got %h want %h", i, got_q[i], mw); else pass_cnt++;
        end
        for (int i = 0; i < N; i++) mem[16'h0010 + 16'(i)] = abc[i];
    endtask

    task automatic test_stall();
        logic [31:0] ew [0:N-1];
        logic [15:0] a;
        logic        rm;
        logic [7:0]  ri;
        for (int it = 0; it < 4; it++) begin
            a = 16'($urandom);
            for (int i = 0; i < N; i++) begin
                mem[16'(a + 16'(i))] = $urandom;
                ew[i] = mword(a, i);
            end
            if (it != 0) begin
                for (int k = 0; k < it; k++) ew[$urandom_range(0, N-1)] ^= (32'h1 << $urandom_range(0, 31));
            end
            set_expected(ew);
            rm = 1'b1; ri = 8'h0;
            for (int i = 0; i < N; i++) begin
                if (rm && mword(a, i) != ew[i]) begin rm = 1'b0; ri = 8'(i); end
            end
            run_collect(a, 1'b1, 1'b0);
            chk_cnt++; if (got_q.size() !== N) $display("FAIL stall%0d_count got %0d want %0d", it, got_q.size(), N); else pass_cnt++;
            chk_cnt++; if (stall_err !== 0) $display("FAIL stall%0d_stable got %0d changes want 0", it, stall_err); else pass_cnt++;
            chk_cnt++; if (done_edge !== hs_edge || done_edge < 0) $display("FAIL stall%0d_done_edge got %0d want %0d", it, done_edge, hs_edge); else pass_cnt++;
            chk_cnt++; if (got_match !== rm || got_midx !== ri) $display("FAIL stall%0d_result got %b/%0d want %b/%0d", it, got_match, got_midx, rm, ri); else pass_cnt++;
            for (int i = 0; i < got_q.size() && i < N; i++) begin
                chk_cnt++; if (got_q[i] !== mword(a, i) || last_q[i] !== (i == N - 1)) $display("FAIL stall%0d_word%0d got %h/%b want %h/%b", it, i, got_q[i], last_q[i], mword(a, i), (i == N - 1)); else pass_cnt++;
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] ea;
        for (int i = 0; i < N; i++) mem[16'(16'hFFFE + 16'(i))] = $urandom;
        run_collect(16'hFFFE, 1'b0, 1'b0);
        chk_cnt++; if (addr_q.size() !== N) $display("FAIL wrap_addr_count got %0d want %0d", addr_q.size(), N); else pass_cnt++;
        for (int i = 0; i < addr_q.size() && i < N; i++) begin
            ea = {16'h0, 16'(16'hFFFE + 16'(i))};
            chk_cnt++; if (addr_q[i] !== ea) $display("FAIL wrap_addr%0d got %h want %h", i, addr_q[i], ea); else pass_cnt++;
        end
        for (int i = 0; i < got_q.size() && i < N; i++) begin
            chk_cnt++; if (got_q[i] !== mword(16'hFFFE, i)) $display("FAIL wrap_word%0d got %h want %h", i, got_q[i], mword(16'hFFFE, i)); else pass_cnt++;
        end
    endtask

    task automatic test_reset_midrun();
        int  hs;
        bit  found;
        set_expected(abc);
        digest_addr = 16'h0010; start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; hs = 0; found = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (out_valid && hs == 3) begin found = 1'b1; break; end
            if (out_valid && out_ready) hs++;
            @(posedge clk); #1;
        end
        chk_cnt++; if (found !== 1'b1) $display("FAIL rst_reach_word3 got %b want 1", found); else pass_cnt++;
        out_ready = 1'b0;
        chk_cnt++; if (out_data !== abc[3]) $display("FAIL rst_word3 got %h want %h", out_data, abc[3]); else pass_cnt++;
        #2 reset_n = 1'b0;
        #1;
        chk_cnt++; if ({out_valid, out_last, done, match} !== 4'b0 || out_data !== 32'h0 || mem_addr !== 32'h0 || mismatch_idx !== 8'h0)
            $display("FAIL rst_midrun got v=%b l=%b d=%b m=%b data=%h addr=%h idx=%0d want all 0", out_valid, out_last, done, match, out_data, mem_addr, mismatch_idx);
        else pass_cnt++;
        @(posedge clk); #1;
        reset_n = 1'b1;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk_cnt++; if (out_valid !== 1'b0 || mem_addr !== 32'h0) $display("FAIL rst_idle got v=%b addr=%h want 0/0", out_valid, mem_addr); else pass_cnt++;
        run_collect(16'h0010, 1'b0, 1'b0);
        chk_cnt++; if (done_edge !== 24 || got_match !== 1'b1 || got_q.size() !== N) $display("FAIL rst_rerun got edge=%0d match=%b words=%0d want 24/1/%0d", done_edge, got_match, got_q.size(), N); else pass_cnt++;
        if (got_q.size() > 0) begin
            chk_cnt++; if (got_q[0] !== abc[0]) $display("FAIL rst_rerun_word0 got %h want %h", got_q[0], abc[0]); else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        int dq[$];
        int mq[$];
        int hs;
        int e;
        set_expected(abc);
        digest_addr = 16'h0010; out_ready = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        e = 0; hs = 0;
        while (e < 74) begin
            @(negedge clk);
            if (out_valid && out_ready) hs++;
            @(posedge clk); #1;
            e++;
            if (done) begin dq.push_back(e); mq.push_back(int'(match)); end
        end
        start = 1'b0;
        chk_cnt++; if (dq.size() !== 3) $display("FAIL b2b_runs got %0d want 3", dq.size()); else pass_cnt++;
        for (int i = 0; i < dq.size(); i++) begin
            chk_cnt++; if (dq[i] !== 24 + 25 * i || mq[i] !== 1) $display("FAIL b2b_run%0d got edge=%0d match=%0d want %0d/1", i, dq[i], mq[i], 24 + 25 * i); else pass_cnt++;
        end
        chk_cnt++; if (hs !== 3 * N) $display("FAIL b2b_words got %0d want %0d", hs, 3 * N); else pass_cnt++;
        repeat (3) @(posedge clk);
        #1;
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL b2b_stop got valid=%b want 0", out_valid); else pass_cnt++;
    endtask

    initial begin
        abc[0] = 32'hba7816bf; abc[1] = 32'h8f01cfea; abc[2] = 32'h414140de; abc[3] = 32'h5dae2223;
        abc[4] = 32'hb00361a3; abc[5] = 32'h96177a9c; abc[6] = 32'hb410ff61; abc[7] = 32'hf20015ad;
        for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
        test_reset();
        test_abc();
        test_mismatch();
        test_stall();
        test_wrap();
        test_reset_midrun();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
